// File: rtl/adc_pkt_pkg.sv
// Shared types and constants for the ADC packet transmitter.
package adc_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam logic [1:0] LEN_216  = 2'b00;
  localparam logic [1:0] LEN_432  = 2'b01;
  localparam logic [1:0] LEN_864  = 2'b10;
  localparam logic [1:0] LEN_1728 = 2'b11;

  // Cycles between the final read and the DONE state (read + pad register + one).
  localparam logic [7:0] DRAIN_CYCLES = 8'd3;

  function automatic logic [10:0] pkt_words(input logic [1:0] code);
    logic [10:0] words;
    case (code)
      LEN_216:  words = 11'd216;
      LEN_432:  words = 11'd432;
      LEN_864:  words = 11'd864;
      LEN_1728: words = 11'd1728;
      default:  words = 11'd216;
    endcase
    return words;
  endfunction

endpackage

// File: rtl/adc_pkt_pattern_gen.sv
// Self-test word counter: cleared at transfer start, advanced per emitted word.
module adc_pkt_pattern_gen #(
  parameter int unsigned DATA_W = 18
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              advance,
  output logic [DATA_W-1:0] pattern
);

  logic [DATA_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (advance) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pattern = cnt_q;

endmodule

// File: rtl/adc_pkt_tx.sv
// ADC capture-buffer to pad packet transmitter (IDLE/PRE/DATA/GAP/DONE).
// Optional self-test counter pattern enabled by define ADC_PKT_SELF_TEST_EN.
module adc_pkt_tx
  import adc_pkt_pkg::*;
#(
  parameter int unsigned DATA_W    = 18,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned MEM_DEPTH = 13824
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        cfg_data_length,
  input  logic [7:0]        cfg_idle_length,
  input  logic [7:0]        cfg_gap,
  input  logic              cfg_self_test,
  input  logic              capture_start,
  input  logic              capture_again,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] adc_data,
  output logic              adc_data_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  state_e            state_q, state_d;
  logic [10:0]       len_q, len_d;
  logic [7:0]        gap_q, gap_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              drain_q, drain_d;
  logic [10:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              vld_pipe_q, vld_pipe_d;
  logic [DATA_W-1:0] adc_data_q, adc_data_d;
  logic              adc_valid_q, adc_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_ok;
  logic [DATA_W-1:0] word_src;

`ifdef ADC_PKT_SELF_TEST_EN
  logic              self_test_q, self_test_d;
  logic [DATA_W-1:0] pattern;

  adc_pkt_pattern_gen #(
    .DATA_W (DATA_W)
  ) u_pattern_gen (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (start_ok),
    .advance (vld_pipe_q),
    .pattern (pattern)
  );

  assign word_src = self_test_q ? pattern : rd_data;
`else
  logic unused_self_test;
  assign unused_self_test = cfg_self_test;
  assign word_src         = rd_data;
`endif

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    gap_d     = gap_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    word_d    = word_q;
    addr_d    = addr_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    start_ok  = 1'b0;
`ifdef ADC_PKT_SELF_TEST_EN
    self_test_d = self_test_q;
`endif

    case (state_q)
      ST_IDLE: begin
        start_ok = capture_start;
      end
      ST_PRE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_DATA: begin
        rd_en_d   = 1'b1;
        rd_addr_d = addr_q;
        word_d    = word_q + 11'd1;
        // Final read takes priority over a packet boundary; GAP then serves as drain.
        if (addr_q == LAST_ADDR) begin
          state_d = ST_GAP;
          drain_d = 1'b1;
          cnt_d   = DRAIN_CYCLES - 8'd1;
        end else begin
          addr_d = addr_q + 1'b1;
          if (word_q == len_q - 11'd1) begin
            word_d = '0;
            if (gap_q != 8'd0) begin
              state_d = ST_GAP;
              cnt_d   = gap_q - 8'd1;
            end
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == 8'd0) begin
          if (drain_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_DONE: begin
        start_ok = capture_start | capture_again;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_ok) begin
      len_d   = pkt_words(cfg_data_length);
      gap_d   = cfg_gap;
      addr_d  = '0;
      word_d  = '0;
      drain_d = 1'b0;
      busy_d  = 1'b1;
`ifdef ADC_PKT_SELF_TEST_EN
      self_test_d = cfg_self_test;
`endif
      if (cfg_idle_length == 8'd0) begin
        state_d = ST_DATA;
      end else begin
        state_d = ST_PRE;
        cnt_d   = cfg_idle_length - 8'd1;
      end
    end
  end

  always_comb begin
    vld_pipe_d  = rd_en_q;
    adc_valid_d = vld_pipe_q;
    adc_data_d  = vld_pipe_q ? word_src : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      gap_q       <= '0;
      cnt_q       <= '0;
      drain_q     <= 1'b0;
      word_q      <= '0;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      vld_pipe_q  <= 1'b0;
      adc_data_q  <= '0;
      adc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef ADC_PKT_SELF_TEST_EN
      self_test_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      vld_pipe_q  <= vld_pipe_d;
      adc_data_q  <= adc_data_d;
      adc_valid_q <= adc_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef ADC_PKT_SELF_TEST_EN
      self_test_q <= self_test_d;
`endif
    end
  end

  assign rd_en          = rd_en_q;
  assign rd_addr        = rd_addr_q;
  assign adc_data       = adc_data_q;
  assign adc_data_valid = adc_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_adc_pkt_tx.sv
// Self-checking bench for adc_pkt_tx against a cycle-indexed pad-stream model.
module tb_adc_pkt_tx;

  localparam int DW    = 18;
  localparam int AW    = 14;
  localparam int DEPTH = 2000;

  logic          clk = 1'b0;
  logic          rstn;
  logic [1:0]    cfg_data_length;
  logic [7:0]    cfg_idle_length;
  logic [7:0]    cfg_gap;
  logic          cfg_self_test;
  logic          capture_start;
  logic          capture_again;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] adc_data;
  logic          adc_data_valid;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  adc_pkt_tx #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .cfg_data_length (cfg_data_length),
    .cfg_idle_length (cfg_idle_length),
    .cfg_gap         (cfg_gap),
    .cfg_self_test   (cfg_self_test),
    .capture_start   (capture_start),
    .capture_again   (capture_again),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .adc_data        (adc_data),
    .adc_data_valid  (adc_data_valid),
    .busy            (busy),
    .done            (done)
  );

  logic [DW-1:0] mem [DEPTH];

  always @(posedge clk) begin
    if (rd_en) rd_data <= (int'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
  end

  int n_assert = 0;
  int n_fail   = 0;

  logic          exp_v [$];
  logic [DW-1:0] exp_d [$];
  logic          cap_v [$];
  logic [DW-1:0] cap_d [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pad stream indexed by cycles after the start-sampling edge.
  task automatic build(input int code, input int idle, input int gap, input bit st);
    int L;
    bit pat;
    L = 216 << code;
`ifdef ADC_PKT_SELF_TEST_EN
    pat = st;
`else
    pat = 1'b0;
`endif
    exp_v.delete();
    exp_d.delete();
    for (int k = 0; k < idle + 3; k++) begin
      exp_v.push_back(1'b0);
      exp_d.push_back('0);
    end
    for (int w = 0; w < DEPTH; w++) begin
      if (w != 0 && (w % L) == 0) begin
        for (int g = 0; g < gap; g++) begin
          exp_v.push_back(1'b0);
          exp_d.push_back('0);
        end
      end
      exp_v.push_back(1'b1);
      exp_d.push_back(pat ? DW'(w) : mem[w]);
    end
  endtask

  task automatic run(input logic [1:0] code, input logic [7:0] idle, input logic [7:0] gap,
                     input bit st, input bit use_again, input bit record, input bit cmp_rec,
                     input int poke);
    int sz;
    int exp_addr;
    logic          ev;
    logic [DW-1:0] ed;
    build(int'(code), int'(idle), int'(gap), st);
    sz = exp_v.size();
    if (record) begin
      cap_v.delete();
      cap_d.delete();
    end
    @(negedge clk);
    cfg_data_length = code;
    cfg_idle_length = idle;
    cfg_gap         = gap;
    cfg_self_test   = st;
    if (use_again) capture_again = 1'b1;
    else           capture_start = 1'b1;
    @(negedge clk);
    capture_start   = 1'b0;
    capture_again   = 1'b0;
    cfg_data_length = 2'($urandom);
    cfg_idle_length = 8'($urandom);
    cfg_gap         = 8'($urandom);
    cfg_self_test   = ~st;
    exp_addr = 0;
    for (int k = 0; k <= sz + 4; k++) begin
      ev = (k < sz) ? exp_v[k] : 1'b0;
      ed = (k < sz) ? exp_d[k] : '0;
      chk("valid", 32'(adc_data_valid), 32'(ev));
      chk("data", 32'(adc_data), 32'(ed));
      chk("done", 32'(done), 32'(k == sz));
      chk("busy", 32'(busy), 32'(k < sz));
      if (rd_en) begin
        chk("rd_addr", 32'(rd_addr), 32'(exp_addr));
        exp_addr++;
      end
      if (record) begin
        cap_v.push_back(adc_data_valid);
        cap_d.push_back(adc_data);
      end
      if (cmp_rec && k < cap_v.size()) begin
        chk("replay_valid", 32'(adc_data_valid), 32'(cap_v[k]));
        chk("replay_data", 32'(adc_data), 32'(cap_d[k]));
      end
      capture_start = (k == poke);
      capture_again = (k == poke);
      @(negedge clk);
    end
    capture_start = 1'b0;
    capture_again = 1'b0;
    chk("rd_count", 32'(exp_addr), 32'(DEPTH));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    rstn            = 1'b0;
    cfg_data_length = 2'b00;
    cfg_idle_length = 8'd0;
    cfg_gap         = 8'd0;
    cfg_self_test   = 1'b0;
    capture_start   = 1'b0;
    capture_again   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(adc_data_valid), 32'd0);
    chk("rst_data", 32'(adc_data), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    capture_again = 1'b1;
    @(negedge clk);
    capture_again = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("again_idle_busy", 32'(busy), 32'd0);
      chk("again_idle_rd_en", 32'(rd_en), 32'd0);
      @(negedge clk);
    end

    run(2'b01, 8'd15, 8'd8, 1'b0, 1'b0, 1'b0, 1'b0, 40);
    run(2'b11, 8'($urandom_range(1, 40)), 8'($urandom_range(1, 20)), 1'b0, 1'b0, 1'b0, 1'b0, -1);
    begin
      logic [7:0] ri, rg;
      ri = 8'($urandom_range(0, 30));
      rg = 8'($urandom_range(1, 12));
      run(2'b10, ri, rg, 1'b0, 1'b0, 1'b1, 1'b0, 700);
      run(2'b10, ri, rg, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    end
    run(2'b00, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1000);
    run(2'($urandom), 8'($urandom_range(0, 10)), 8'($urandom_range(1, 10)), 1'b1, 1'b1, 1'b0, 1'b0, -1);

    @(negedge clk);
    cfg_data_length = 2'b00;
    cfg_idle_length = 8'd0;
    cfg_gap         = 8'd3;
    cfg_self_test   = 1'b0;
    capture_start   = 1'b1;
    @(negedge clk);
    capture_start = 1'b0;
    repeat (30) @(negedge clk);
    chk("pre_rst_valid", 32'(adc_data_valid), 32'd1);
    rstn = 1'b0;
    #1;
    chk("arst_valid", 32'(adc_data_valid), 32'd0);
    chk("arst_data", 32'(adc_data), 32'd0);
    chk("arst_rd_en", 32'(rd_en), 32'd0);
    chk("arst_rd_addr", 32'(rd_addr), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_valid", 32'(adc_data_valid), 32'd0);
      chk("post_rst_rd_en", 32'(rd_en), 32'd0);
      chk("post_rst_done", 32'(done), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_pkt_tx.md
# adc_pkt_tx

Packet transmitter between the ADC capture buffer and the ADC data output pads. After a capture completes, it reads stored 18-bit samples from the buffer's synchronous read port. It frames them into fixed-length packets separated by configurable idle and gap intervals, and drives the PAD ADC_DATA[18:1] / ADC_DATA_VALID outputs. Configuration comes from the top regfile fields pktctrl_gap, pkt_data_length, pkt_idle_length, capture_start, capture_again and self_test_mode.

## Interface
- DATA_W, 18: sample width; equals the pad data width.
- ADDR_W, 14: capture buffer address width.
- MEM_DEPTH, 13824: number of valid words in the buffer; must be ≤ 2^ADDR_W.
- clk  in  1  system clock; also used as the pad read clock.
- rstn  in  1  reset, asynchronous assert, active-low.
- cfg_data_length  in  2  packet length code: 00=216, 01=432, 10=864, 11=1728 words.
- cfg_idle_length  in  8  number of idle cycles before the first packet.
- cfg_gap  in  8  number of idle cycles between packets.
- cfg_self_test  in  1  replace buffer data with a counter pattern.
- capture_start  in  1  pulse; begins a transfer from address 0.
- capture_again  in  1  pulse; repeats the transfer after DONE.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  ADDR_W  buffer read address.
- rd_data  in  DATA_W  buffer data, valid one cycle after rd_en.
- adc_data  out  DATA_W  pad data; 0 whenever adc_data_valid=0.
- adc_data_valid  out  1  pad data qualifier.
- busy  out  1  high from the start-accept cycle until DONE.
- done  out  1  one-cycle pulse when the last word leaves the block.

## Operation
- States are IDLE, PRE, DATA, GAP and DONE.
- IDLE: capture_start=1 latches all cfg_* inputs, clears the address and word counters, and moves to PRE (or to DATA if idle_length=0).
- PRE: counts idle_length cycles, then moves to DATA.
- DATA: issues one rd_en per cycle with an incrementing rd_addr.
  - After L words (L=216<<code), the state moves to GAP, or to DATA directly if gap=0.
  - When rd_addr reaches MEM_DEPTH-1, that is the final read; the last packet may be shorter than L. After the pipeline drains, the state moves to DONE.
- GAP: counts gap cycles, then returns to DATA.
- DONE: asserts done for one cycle and deasserts busy.
  - capture_again=1 or capture_start=1 in DONE relatches cfg and restarts exactly as from IDLE.
  - Otherwise the block holds in DONE.
- Starts and agains are ignored while busy. capture_again is ignored in IDLE.
- cfg_* changes mid-transfer have no effect.
- Word counter is 11 bits; address counter is ADDR_W bits with no wrap. The transfer ends at MEM_DEPTH words.

## Timing
- Reset values:
  - adc_data = 0, adc_data_valid = 0, rd_en = 0, rd_addr = 0, busy = 0, done = 0; state IDLE.
  - Asserting rstn mid-transfer aborts immediately with no partial flush.
- busy rises on the cycle after the clock edge that samples capture_start.
- Read-to-pad latency is 2: rd_en in cycle t gives rd_data in t+1; adc_data/adc_data_valid are registered in t+2.
- First adc_data_valid appears idle_length+3 cycles after the start-sample edge.
- Inter-packet spacing equals exactly gap invalid cycles on the pads.
- done pulses in the cycle after the last valid word.

## Configuration
- ADC_PKT_SELF_TEST_EN defined:
  - When cfg_self_test=1, the output word is an 18-bit counter. It resets to 0 at each transfer start and increments per emitted word, continuing across packets.
  - rd_en still toggles, but rd_data is ignored.
- ADC_PKT_SELF_TEST_EN undefined: the generator is absent and cfg_self_test is ignored.

## Structure
- Shared package adc_pkt_pkg contains:
  - the state enum;
  - length-code constants;
  - a function mapping the 2-bit length code to an 11-bit word count.
- One sub-module, adc_pkt_pattern_gen: the self-test counter. It is instantiated only under ADC_PKT_SELF_TEST_EN.

## Test plan
- code=01, idle=15, gap=8, MEM_DEPTH=13824, start pulse:
  - 32 packets of 432 valid words, each preceded by 8 invalid cycles;
  - first valid word arrives 18 cycles after the start edge;
  - done fires once.
- code=11, MEM_DEPTH=2000:
  - one 1728-word packet, gap, then a truncated 272-word packet, then done.
- gap=0, idle=0, code=00:
  - adc_data_valid stays continuously high from the 3rd cycle until done;
  - rd_addr sequence is 0..MEM_DEPTH-1 with no skips.
- Start pulse while busy is ignored. capture_again in DONE replays an identical pad stream; compare word-for-word.
- Self-test on with the macro defined: pad words are 0,1,2,… across packet boundaries. With the macro undefined: buffer data appears instead.
- rstn low in the middle of a DATA packet:
  - all outputs are 0 within the same cycle;
  - after release, the block stays in IDLE until the next start.
